frame_ctrl: RTL and testbench
=============================

# frame_ctrl

Frame controller and UART-TX arbiter between the UART core and the image filter. It parses a framing header from the UART receive stream and programs the block length. It then gates exactly that many payload bytes into the filter and returns ACK/NAK bytes to the host. The UART transmitter is shared between its own response bytes and the filter's output bytes.

## Interface
- D_BITS, 8, UART data width
- N, 400, maximum legal block length; also the reset value of o_bleng
- SYNC, 8'hA5, frame start byte
- ACK, 8'h06, header-accepted response byte
- NAK, 8'h15, error response byte
- TIMEOUT, 1_000_000, max idle cycles between bytes inside a frame

Ports:
- i_clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- i_rx_data  in  D_BITS  byte from UART receiver
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_tx_rdy  in  1  UART transmitter idle
- o_tx_data  out  D_BITS  byte to UART transmitter
- o_tx_send  out  1  one-cycle transmit request
- o_bleng  out  32  block length to filter
- o_f_data  out  D_BITS  payload byte to filter (= i_rx_data)
- o_f_valid  out  1  payload strobe to filter
- i_f_data  in  D_BITS  filter output byte
- i_f_send  in  1  filter transmit request
- o_f_rdy  out  1  transmitter ready as seen by filter
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse on the last payload byte
- o_err  out  1  one-cycle pulse when NAK is queued

## Operation
- States: IDLE, LEN, PAYLOAD.
- IDLE: on i_rx_valid with byte==SYNC, clear len register and byte index, go to LEN. Any other byte is discarded.
- LEN: accept 4 bytes, little-endian, into a 32-bit len register.
  - After the 4th byte, check 1 <= len <= N.
  - Pass: o_bleng<=len, count<=0, queue ACK, go to PAYLOAD.
  - Fail: queue NAK, pulse o_err, go to IDLE. o_bleng is unchanged.
- PAYLOAD: combinational o_f_valid = i_rx_valid and o_f_data = i_rx_data, zero latency.
  - count increments per byte.
  - On the byte where count==o_bleng-1: pulse o_done, go to IDLE.
  - SYNC bytes inside the payload are data, not a restart.
- Timeout: in LEN or PAYLOAD, an idle counter resets on each i_rx_valid. On reaching TIMEOUT: queue NAK, pulse o_err, go to IDLE.
- Response queue: single slot, tx_pend plus tx_byte.
  - A new queue request overwrites a pending byte; the later event wins.
- TX arbitration:
  - o_f_rdy = i_tx_rdy & ~tx_pend.
  - When tx_pend & i_tx_rdy: o_tx_send=1, o_tx_data=tx_byte, clear tx_pend.
  - Otherwise o_tx_send=i_f_send & o_f_rdy, o_tx_data=i_f_data.
  - Controller responses have priority over the filter.
- Filter sends while o_f_rdy=0 are ignored; the filter must wait for ready.

## Timing
- Reset (reset==0 at a clock edge) produces:
  - state=IDLE, tx_pend=0, counters=0, o_bleng=N.
  - o_tx_send=0, o_f_valid=0, o_f_rdy=i_tx_rdy, o_busy=0, o_done=0, o_err=0.
- Reset mid-frame aborts with no NAK; pending responses are dropped.
- Header: the 4th length byte at cycle t gives o_bleng updated and tx_pend=1 at t+1. o_tx_send goes high at t+1 if i_tx_rdy.
- o_done and o_f_valid for the last byte occur in the same cycle. o_busy falls the next cycle.
- The first payload byte may arrive while ACK is still pending; it is forwarded normally.
- NAK and the filter request in the same cycle: NAK is sent, filter sees o_f_rdy=0.
- o_tx_send is at most one cycle per granted byte; nothing is issued while i_tx_rdy=0.
- count and len are 32-bit; len=0 and len>N both take the NAK path.

## Test plan
- Valid frame: A5 05 00 00 00 then 5 bytes 11..15 -> ACK 06 sent once, o_bleng=5, o_f_valid exactly 5 strobes with 11..15, o_done on the 5th, back in IDLE.
- Bad length: A5 91 01 00 00 (401) -> NAK 15, o_err pulse, o_bleng stays 400, no o_f_valid.
- Timeout: A5 03 00 00 00, 1 payload byte, then silence for TIMEOUT cycles -> NAK, o_err, IDLE; next valid frame accepted.
- Arbitration: i_f_send held high during an ACK queue with i_tx_rdy=1 -> ACK transmitted first, o_f_rdy=0 that cycle, filter byte sent the next ready cycle.
- Reset mid-payload after 2 of 5 bytes -> all outputs at reset values, o_bleng=400, no NAK. The following byte A5 starts a new header.
- Noise in IDLE: bytes 00 FF 7E -> ignored; o_busy stays 0.

Source files
------------

// File: rtl/frame_ctrl.sv
// frame_ctrl: parses a SYNC + 4-byte little-endian length header from the
// UART receive stream. It then forwards exactly that many payload bytes to
// the image filter, and it shares the UART transmitter between its own
// ACK/NAK responses and the filter's output bytes.
//
// Handshake semantics: i_rx_valid and o_f_valid are one-cycle strobes with
// no back-pressure. The transmitter accepts a byte in any cycle where
// o_tx_send=1, and o_tx_send is only raised while i_tx_rdy=1. The filter
// may transmit only in a cycle where it sees o_f_rdy=1. A request made
// while o_f_rdy=0 is dropped, so the filter must hold it until ready.
module frame_ctrl #(
  parameter int          D_BITS  = 8,
  parameter int          N       = 400,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [7:0]  ACK     = 8'h06,
  parameter logic [7:0]  NAK     = 8'h15,
  parameter int          TIMEOUT = 1_000_000
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [D_BITS-1:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_tx_rdy,
  output logic [D_BITS-1:0] o_tx_data,
  output logic              o_tx_send,
  output logic [31:0]       o_bleng,
  output logic [D_BITS-1:0] o_f_data,
  output logic              o_f_valid,
  input  logic [D_BITS-1:0] i_f_data,
  input  logic              i_f_send,
  output logic              o_f_rdy,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_state
);

  localparam int               IW      = $clog2(TIMEOUT + 1);
  localparam logic [31:0]      N_W     = 32'(N);
  localparam logic [IW-1:0]    TO_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       len_q;
  logic [31:0]       count;
  logic [1:0]        byte_idx;
  logic [IW-1:0]     idle_cnt;
  logic              tx_pend;
  logic [D_BITS-1:0] tx_byte;

  logic [31:0]       len_next;
  logic              tx_grant;
  logic              timeout_hit;

  // Header assembly, arbitration and the zero-latency payload path.
  always_comb begin
    len_next    = {i_rx_data[7:0], len_q[31:8]};
    tx_grant    = tx_pend & i_tx_rdy;
    o_f_rdy     = i_tx_rdy & ~tx_pend;
    o_tx_send   = tx_grant | (i_f_send & o_f_rdy);
    o_tx_data   = tx_grant ? tx_byte : i_f_data;
    o_f_valid   = (state == S_PAYLOAD) & i_rx_valid;
    o_f_data    = i_rx_data;
    o_done      = o_f_valid & (count == (o_bleng - 32'd1));
    o_busy      = (state != S_IDLE);
    o_state     = state;
    timeout_hit = (state != S_IDLE) & ~i_rx_valid & (idle_cnt == TO_LAST);
  end

  // Frame FSM, response slot and idle timer. A later queue request in the
  // same cycle overrides the slot clear that follows a grant.
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      len_q    <= '0;
      count    <= '0;
      byte_idx <= '0;
      idle_cnt <= '0;
      tx_pend  <= 1'b0;
      tx_byte  <= '0;
      o_bleng  <= N_W;
      o_err    <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (tx_grant) tx_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_rx_valid && (i_rx_data[7:0] == SYNC)) begin
            len_q    <= '0;
            byte_idx <= '0;
            idle_cnt <= '0;
            state    <= S_LEN;
          end
        end
        S_LEN: begin
          if (i_rx_valid) begin
            idle_cnt <= '0;
            len_q    <= len_next;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              tx_pend <= 1'b1;
              if ((len_next != 32'd0) && (len_next <= N_W)) begin
                o_bleng <= len_next;
                count   <= '0;
                tx_byte <= D_BITS'(ACK);
                state   <= S_PAYLOAD;
              end else begin
                tx_byte <= D_BITS'(NAK);
                o_err   <= 1'b1;
                state   <= S_IDLE;
              end
            end
          end else if (timeout_hit) begin
            tx_pend <= 1'b1;
            tx_byte <= D_BITS'(NAK);
            o_err   <= 1'b1;
            state   <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        S_PAYLOAD: begin
          if (i_rx_valid) begin
            idle_cnt <= '0;
            count    <= count + 32'd1;
            if (o_done) state <= S_IDLE;
          end else if (timeout_hit) begin
            tx_pend <= 1'b1;
            tx_byte <= D_BITS'(NAK);
            o_err   <= 1'b1;
            state   <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_ctrl.sv
// Bench for frame_ctrl: directed header/arbitration/timeout/reset cases plus
// randomized frames, scored against expected byte streams and event counts.
module tb_frame_ctrl;

  localparam int          TO   = 40;
  localparam int          NMAX = 400;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [7:0]  ACKB = 8'h06;
  localparam logic [7:0]  NAKB = 8'h15;

  logic        i_clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        i_tx_rdy = 1'b1;
  logic [7:0]  o_tx_data;
  logic        o_tx_send;
  logic [31:0] o_bleng;
  logic [7:0]  o_f_data;
  logic        o_f_valid;
  logic [7:0]  i_f_data = '0;
  logic        i_f_send = 1'b0;
  logic        o_f_rdy;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [1:0]  o_state;

  frame_ctrl #(.D_BITS(8), .N(NMAX), .SYNC(SYNC), .ACK(ACKB), .NAK(NAKB),
               .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .reset(reset), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid), .i_tx_rdy(i_tx_rdy), .o_tx_data(o_tx_data),
    .o_tx_send(o_tx_send), .o_bleng(o_bleng), .o_f_data(o_f_data),
    .o_f_valid(o_f_valid), .i_f_data(i_f_data), .i_f_send(i_f_send),
    .o_f_rdy(o_f_rdy), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_state(o_state)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_f_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_done = 0;
  int          exp_err  = 0;
  int          obs_done = 0;
  int          obs_err  = 0;
  logic [31:0] exp_bleng = 32'(NMAX);

  // Transmitter-ready driver: random with at most 3 busy cycles in a row,
  // or a fixed level for directed tests.
  logic rdy_rand  = 1'b0;
  logic rdy_fixed = 1'b1;
  int   low_run   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
    n_checks++;
    if (obs === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
  endtask

  always @(posedge i_clk) begin
    #1;
    if (rdy_rand) begin
      if (low_run >= 3 || $urandom_range(0, 3) != 0) begin
        i_tx_rdy = 1'b1;
        low_run  = 0;
      end else begin
        i_tx_rdy = 1'b0;
        low_run++;
      end
    end else begin
      i_tx_rdy = rdy_fixed;
    end
  end

  // Monitor: every forwarded byte and transmitted byte is matched in order.
  always @(negedge i_clk) begin
    if (reset) begin
      if (o_f_valid) begin
        check("f_expected", 32'(exp_f_q.size() != 0), 32'd1);
        if (exp_f_q.size() != 0) check("f_data", 32'(o_f_data), 32'(exp_f_q.pop_front()));
      end
      if (o_tx_send) begin
        check("tx_only_when_rdy", 32'(i_tx_rdy), 32'd1);
        check("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
        if (exp_tx_q.size() != 0) check("tx_data", 32'(o_tx_data), 32'(exp_tx_q.pop_front()));
      end
      if (o_done) begin
        obs_done++;
        check("done_with_valid", 32'(o_f_valid), 32'd1);
      end
      if (o_err) obs_err++;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask

  task automatic gap();
    idle($urandom_range(0, 3));
  endtask

  task automatic end_checks(input string tag);
    idle(5);
    @(negedge i_clk);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_bleng"}, o_bleng, exp_bleng);
    check({tag, "_done_cnt"}, 32'(obs_done), 32'(exp_done));
    check({tag, "_err_cnt"}, 32'(obs_err), 32'(exp_err));
    check({tag, "_f_left"}, 32'(exp_f_q.size()), 32'd0);
    check({tag, "_tx_left"}, 32'(exp_tx_q.size()), 32'd0);
    tick();
  endtask

  // One frame. kind 0: complete, 1: stall inside the header, 2: stall
  // inside the payload. The expected streams follow from the framing rules.
  task automatic run_frame(input logic [31:0] len, input int kind);
    logic [31:0] l;
    int          nbytes;
    logic [7:0]  b;
    l = len;
    send_byte(SYNC);
    gap();
    if (kind == 1) begin
      nbytes = $urandom_range(0, 3);
      for (int i = 0; i < nbytes; i++) begin
        send_byte(l[8*i +: 8]);
        gap();
      end
      exp_tx_q.push_back(NAKB);
      exp_err++;
      idle(TO + 2);
    end else begin
      if (l >= 32'd1 && l <= 32'(NMAX)) begin
        exp_tx_q.push_back(ACKB);
        exp_bleng = l;
        nbytes = (kind == 2) ? $urandom_range(0, int'(l) - 1) : int'(l);
        if (kind != 2) exp_done++;
      end else begin
        exp_tx_q.push_back(NAKB);
        exp_err++;
        nbytes = 0;
      end
      for (int i = 0; i < 4; i++) begin
        send_byte(l[8*i +: 8]);
        if (i != 3) gap();
      end
      for (int i = 0; i < nbytes; i++) begin
        gap();
        b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
        exp_f_q.push_back(b);
        send_byte(b);
      end
      if (kind == 2) begin
        exp_tx_q.push_back(NAKB);
        exp_err++;
        idle(TO + 2);
      end
    end
  endtask

  initial begin
    logic [31:0] len;
    int          k;
    int          e0;
    int          d0;
    // Reset state
    reset = 1'b0;
    idle(3);
    @(negedge i_clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_bleng", o_bleng, 32'(NMAX));
    check("rst_tx_send", 32'(o_tx_send), 32'd0);
    check("rst_f_valid", 32'(o_f_valid), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_f_rdy_hi", 32'(o_f_rdy), 32'd1);
    rdy_fixed = 1'b0;
    tick();
    @(negedge i_clk);
    check("rst_f_rdy_lo", 32'(o_f_rdy), 32'd0);
    rdy_fixed = 1'b1;
    tick();
    reset = 1'b1;
    tick();

    // Noise in IDLE
    foreach (exp_f_q[i]) exp_f_q.delete();
    send_byte(8'h00);
    @(negedge i_clk); check("noise00_busy", 32'(o_busy), 32'd0);
    send_byte(8'hFF);
    @(negedge i_clk); check("noiseFF_busy", 32'(o_busy), 32'd0);
    send_byte(8'h7E);
    @(negedge i_clk); check("noise7E_busy", 32'(o_busy), 32'd0);
    end_checks("noise");

    // Valid frame with fixed payload 11..15
    send_byte(SYNC);
    exp_tx_q.push_back(ACKB);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    @(negedge i_clk);
    check("hdr_bleng_t1", o_bleng, 32'd5);
    check("hdr_ack_send_t1", 32'(o_tx_send), 32'd1);
    exp_bleng = 32'd5;
    for (int i = 0; i < 5; i++) begin
      exp_f_q.push_back(8'(8'h11 + i));
      send_byte(8'(8'h11 + i));
    end
    exp_done++;
    @(negedge i_clk);
    check("valid_busy_after_done", 32'(o_busy), 32'd0);
    end_checks("valid");

    // Bad length 401, then the length boundaries 0, 1, N
    run_frame(32'd401, 0);   end_checks("len401");
    run_frame(32'd0, 0);     end_checks("len0");
    run_frame(32'h0100_0001, 0); end_checks("lenbig");
    run_frame(32'd1, 0);     end_checks("len1");
    run_frame(32'(NMAX), 0); end_checks("lenN");

    // Arbitration: filter requests while the ACK is pending
    send_byte(SYNC);
    exp_tx_q.push_back(ACKB);
    exp_tx_q.push_back(8'h5C);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    i_f_send = 1'b1;
    i_f_data = 8'h5C;
    @(negedge i_clk);
    check("arb_ack_send", 32'(o_tx_send), 32'd1);
    check("arb_ack_data", 32'(o_tx_data), 32'(ACKB));
    check("arb_f_rdy_lo", 32'(o_f_rdy), 32'd0);
    tick();
    @(negedge i_clk);
    check("arb_f_rdy_hi", 32'(o_f_rdy), 32'd1);
    check("arb_f_data", 32'(o_tx_data), 32'h5C);
    tick();
    i_f_send = 1'b0;
    exp_bleng = 32'd2;
    exp_f_q.push_back(8'h21); send_byte(8'h21);
    exp_f_q.push_back(8'h22); send_byte(8'h22);
    exp_done++;
    end_checks("arb");

    // Timeout inside the payload: err appears after TO idle cycles
    send_byte(SYNC);
    exp_tx_q.push_back(ACKB);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    exp_bleng = 32'd3;
    idle(2);
    exp_f_q.push_back(8'h44);
    send_byte(8'h44);
    exp_tx_q.push_back(NAKB);
    exp_err++;
    idle(TO - 1);
    @(negedge i_clk);
    check("to_still_busy", 32'(o_busy), 32'd1);
    check("to_no_err_yet", 32'(o_err), 32'd0);
    tick();
    @(negedge i_clk);
    check("to_err_pulse", 32'(o_err), 32'd1);
    check("to_idle", 32'(o_busy), 32'd0);
    end_checks("timeout");
    run_frame(32'd4, 0); end_checks("after_to");

    // Reset mid-payload after 2 of 5 bytes
    send_byte(SYNC);
    exp_tx_q.push_back(ACKB);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    exp_bleng = 32'd5;
    idle(2);
    exp_f_q.push_back(8'h31); send_byte(8'h31);
    exp_f_q.push_back(8'h32); send_byte(8'h32);
    e0 = obs_err;
    d0 = obs_done;
    reset = 1'b0;
    idle(2);
    @(negedge i_clk);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_bleng", o_bleng, 32'(NMAX));
    check("mid_rst_tx_send", 32'(o_tx_send), 32'd0);
    reset = 1'b1;
    exp_bleng = 32'(NMAX);
    idle(TO + 5);
    @(negedge i_clk);
    check("mid_rst_no_nak", 32'(obs_err - e0), 32'd0);
    check("mid_rst_no_done", 32'(obs_done - d0), 32'd0);
    end_checks("mid_rst");
    run_frame(32'd3, 0); end_checks("after_rst");

    // Randomized frames
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      k = $urandom_range(0, 9);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++)
        send_byte(8'($urandom_range(0, 8'hA4)));
      if (k < 5) len = 32'($urandom_range(1, 12));
      else if (k == 5) len = 32'($urandom_range(NMAX + 1, 1000));
      else if (k == 6) len = {8'($urandom_range(1, 255)), 24'($urandom)};
      else len = 32'($urandom_range(1, 12));
      if (k == 7) run_frame(len, 1);
      else if (k == 8) run_frame(len, 2);
      else run_frame(len, 0);
      end_checks("rand");
    end
    rdy_rand = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
